// File: rtl/register_bank_if.sv
// Addressed control/read port of register_bank: one op per clock plus a combinational read.
// The parameters must match the register_bank instance this interface connects to.
interface register_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CTRL_WIDTH = 3
);
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_input;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_output;
    logic [NUM_REGS-1:0]   zero;
    logic [NUM_REGS-1:0]   ovf;

    modport master (
        output ctrl, wr_addr, data_input, rd_addr,
        input  data_output, zero, ovf
    );

    modport slave (
        input  ctrl, wr_addr, data_input, rd_addr,
        output data_output, zero, ovf
    );
endinterface

// File: rtl/register_bank.sv
// Bank of NUM_REGS registers with clear/load/inc/dec/shift ops, per-register zero and sticky ovf flags.
// Define REGISTER_BANK_SATURATE_EN to make INCR/DECR saturate instead of wrapping.
module register_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CTRL_WIDTH = 3
) (
    input  logic           clk,
    input  logic           rst,
    register_bank_if.slave bus
);
    localparam logic [CTRL_WIDTH-1:0] OP_NONE    = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] OP_CLR     = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] OP_LOAD    = CTRL_WIDTH'(2);
    localparam logic [CTRL_WIDTH-1:0] OP_INCR    = CTRL_WIDTH'(3);
    localparam logic [CTRL_WIDTH-1:0] OP_DECR    = CTRL_WIDTH'(4);
    localparam logic [CTRL_WIDTH-1:0] OP_SHL     = CTRL_WIDTH'(5);
    localparam logic [CTRL_WIDTH-1:0] OP_SHR     = CTRL_WIDTH'(6);
    localparam logic [CTRL_WIDTH-1:0] OP_CLR_ALL = CTRL_WIDTH'(7);

`ifdef REGISTER_BANK_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] value_arr [NUM_REGS];
    logic [NUM_REGS-1:0]   ovf_vec;
    logic [NUM_REGS-1:0]   zero_vec;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  clr_all;

    assign clr_all = (bus.ctrl == OP_CLR_ALL);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic [DATA_WIDTH-1:0] value_next;
            logic                  ovf_reg;
            logic                  ovf_next;
            logic                  sel;

            // Out-of-range wr_addr never matches any index, so those ops fall through as no-ops.
            assign sel = (bus.wr_addr == ADDR_WIDTH'(gi));

            always_comb begin
                value_next = value_reg;
                ovf_next   = ovf_reg;
                if (clr_all) begin
                    value_next = '0;
                    ovf_next   = 1'b0;
                end else if (sel) begin
                    case (bus.ctrl)
                        OP_NONE: ;
                        OP_CLR: begin
                            value_next = '0;
                            ovf_next   = 1'b0;
                        end
                        OP_LOAD: value_next = bus.data_input;
                        OP_INCR: begin
                            if (value_reg == '1) begin
                                ovf_next   = 1'b1;
                                value_next = SATURATE ? value_reg : '0;
                            end else begin
                                value_next = value_reg + DATA_WIDTH'(1);
                            end
                        end
                        OP_DECR: begin
                            if (value_reg == '0) begin
                                ovf_next   = 1'b1;
                                value_next = SATURATE ? value_reg : '1;
                            end else begin
                                value_next = value_reg - DATA_WIDTH'(1);
                            end
                        end
                        OP_SHL: begin
                            value_next = {value_reg[DATA_WIDTH-2:0], 1'b0};
                            if (value_reg[DATA_WIDTH-1]) ovf_next = 1'b1;
                        end
                        OP_SHR: value_next = {1'b0, value_reg[DATA_WIDTH-1:1]};
                        default: ;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    value_reg <= '0;
                    ovf_reg   <= 1'b0;
                end else begin
                    value_reg <= value_next;
                    ovf_reg   <= ovf_next;
                end
            end

            assign value_arr[gi] = value_reg;
            assign ovf_vec[gi]   = ovf_reg;
        end
    endgenerate

    // Read port sees stored state only; an unmatched rd_addr yields zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr == ADDR_WIDTH'(i)) rd_data = value_arr[i];
        end
    end

    always_comb begin
        zero_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            zero_vec[i] = (value_arr[i] == '0);
        end
    end

    assign bus.data_output = rd_data;
    assign bus.zero        = zero_vec;
    assign bus.ovf         = ovf_vec;
endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank; expectations follow REGISTER_BANK_SATURATE_EN.
module tb_register_bank;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    localparam logic [2:0] NONE = 3'd0, CLR = 3'd1, LOAD = 3'd2, INCR = 3'd3,
                           DECR = 3'd4, SHL = 3'd5, SHR = 3'd6, CLR_ALL = 3'd7;

`ifdef REGISTER_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   failed;

    register_bank_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) bus ();

    register_bank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one op for one rising edge, then return to NONE (called at a falling edge).
    task automatic apply(input logic [2:0] c, input logic [1:0] wa, input logic [7:0] d, input logic [1:0] ra);
        bus.ctrl       = c;
        bus.wr_addr    = wa;
        bus.data_input = d;
        bus.rd_addr    = ra;
        @(negedge clk);
        bus.ctrl = NONE;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [1:0] ra, input logic [7:0] exp);
        bus.rd_addr = ra;
        #1;
        check(tag, {24'd0, bus.data_output}, {24'd0, exp});
    endtask

    initial begin
        total  = 0;
        failed = 0;
        rst    = 1'b1;
        bus.ctrl       = NONE;
        bus.wr_addr    = 2'd0;
        bus.data_input = 8'h00;
        bus.rd_addr    = 2'd0;
        repeat (2) @(negedge clk);

        // Preload a value, then pulse reset between edges.
        rst = 1'b0;
        apply(LOAD, 2'd1, 8'h5A, 2'd1);
        read_check("preload", 2'd1, 8'h5A);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        for (int r = 0; r < NR; r++) read_check($sformatf("rst_rd%0d", r), 2'(r), 8'h00);
        check("rst_zero", {28'd0, bus.zero}, 32'hF);
        check("rst_ovf", {28'd0, bus.ovf}, 32'h0);

        // LOAD with a same-cycle read of the target returns the old value.
        bus.ctrl = LOAD; bus.wr_addr = 2'd2; bus.data_input = 8'hA5; bus.rd_addr = 2'd2;
        #1 check("load_same_cyc", {24'd0, bus.data_output}, 32'h00);
        @(negedge clk);
        bus.ctrl = NONE;
        #1 check("load_rd", {24'd0, bus.data_output}, 32'hA5);
        check("load_zero", {28'd0, bus.zero}, 32'hB);

        // Wrap/saturate at all-ones on reg 1.
        apply(LOAD, 2'd1, 8'hFE, 2'd1);
        apply(INCR, 2'd1, 8'h00, 2'd1);
        check("incr_ff", {24'd0, bus.data_output}, 32'hFF);
        check("incr_ff_ovf", {28'd0, bus.ovf}, 32'h0);
        apply(INCR, 2'd1, 8'h00, 2'd1);
        check("incr_top", {24'd0, bus.data_output}, SAT ? 32'hFF : 32'h00);
        check("incr_top_ovf", {28'd0, bus.ovf}, 32'h2);
        check("incr_top_zero", {28'd0, bus.zero}, SAT ? 32'h9 : 32'hB);
        apply(CLR, 2'd1, 8'h00, 2'd1);
        check("clr_ovf", {28'd0, bus.ovf}, 32'h0);
        check("clr_val", {24'd0, bus.data_output}, 32'h00);

        // Decrement through zero on reg 0.
        apply(LOAD, 2'd0, 8'h01, 2'd0);
        apply(DECR, 2'd0, 8'h00, 2'd0);
        check("decr_1", {24'd0, bus.data_output}, 32'h00);
        check("decr_1_ovf", {28'd0, bus.ovf}, 32'h0);
        apply(DECR, 2'd0, 8'h00, 2'd0);
        check("decr_2", {24'd0, bus.data_output}, SAT ? 32'h00 : 32'hFF);
        apply(DECR, 2'd0, 8'h00, 2'd0);
        check("decr_3", {24'd0, bus.data_output}, SAT ? 32'h00 : 32'hFE);
        check("decr_ovf", {28'd0, bus.ovf}, 32'h1);
        apply(LOAD, 2'd0, 8'hFF, 2'd0);
        check("load_keep_ovf", {28'd0, bus.ovf}, 32'h1);
        apply(INCR, 2'd0, 8'h00, 2'd0);
        check("incr_ff_r0", {24'd0, bus.data_output}, SAT ? 32'hFF : 32'h00);
        apply(CLR, 2'd0, 8'h00, 2'd0);
        check("clr_r0_ovf", {28'd0, bus.ovf}, 32'h0);

        // Shifts on reg 3 with isolation of the others.
        apply(LOAD, 2'd3, 8'h81, 2'd3);
        apply(SHL, 2'd3, 8'h00, 2'd3);
        check("shl", {24'd0, bus.data_output}, 32'h02);
        check("shl_ovf", {28'd0, bus.ovf}, 32'h8);
        apply(SHR, 2'd3, 8'h00, 2'd3);
        check("shr_1", {24'd0, bus.data_output}, 32'h01);
        apply(SHR, 2'd3, 8'h00, 2'd3);
        check("shr_2", {24'd0, bus.data_output}, 32'h00);
        check("shr_zero", {28'd0, bus.zero}, 32'hB);
        check("shr_ovf", {28'd0, bus.ovf}, 32'h8);
        read_check("iso_r0", 2'd0, 8'h00);
        read_check("iso_r1", 2'd1, 8'h00);
        read_check("iso_r2", 2'd2, 8'hA5);

        // Build ovf=0110 with nonzero contents, then CLR_ALL.
        apply(LOAD, 2'd0, 8'h11, 2'd0);
        apply(LOAD, 2'd1, 8'hFF, 2'd1);
        apply(INCR, 2'd1, 8'h00, 2'd1);
        apply(LOAD, 2'd1, 8'h22, 2'd1);
        apply(LOAD, 2'd2, 8'hC0, 2'd2);
        apply(SHL, 2'd2, 8'h00, 2'd2);
        check("shl_c0", {24'd0, bus.data_output}, 32'h80);
        apply(CLR, 2'd3, 8'h00, 2'd3);
        apply(LOAD, 2'd3, 8'h33, 2'd3);
        check("pre_ovf", {28'd0, bus.ovf}, 32'h6);
        check("pre_zero", {28'd0, bus.zero}, 32'h0);
        apply(CLR_ALL, 2'd2, 8'h00, 2'd0);
        check("clrall_ovf", {28'd0, bus.ovf}, 32'h0);
        check("clrall_zero", {28'd0, bus.zero}, 32'hF);
        read_check("clrall_r1", 2'd1, 8'h00);
        read_check("clrall_r3", 2'd3, 8'h00);

        // Held INCR counts every edge; reset mid-run clears at once and swallows the reset-cycle op.
        bus.ctrl = INCR; bus.wr_addr = 2'd0; bus.rd_addr = 2'd0;
        @(negedge clk);
        #1 check("hold_1", {24'd0, bus.data_output}, 32'h01);
        @(negedge clk);
        @(negedge clk);
        #1 check("hold_3", {24'd0, bus.data_output}, 32'h03);
        #1 rst = 1'b1;
        #1 check("rst_async", {24'd0, bus.data_output}, 32'h00);
        @(negedge clk);
        #1 check("rst_cycle", {24'd0, bus.data_output}, 32'h00);
        rst = 1'b0;
        @(negedge clk);
        #1 check("post_rst", {24'd0, bus.data_output}, 32'h01);
        bus.ctrl = NONE;
        @(negedge clk);
        #1 check("idle_hold", {24'd0, bus.data_output}, 32'h01);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
